// File: rtl/uart_tx_16x.sv
// uart_tx_16x - serial UART transmitter timed from a 16x oversample clock.
//
// Frames parallel words onto txd: idle high, one start bit (low), DATA_BITS
// data bits LSB first, an optional even parity bit, then STOP_BITS stop bits
// (high). Every bit lasts OVERSAMPLE ticks, where a tick is a one-cycle pulse
// made from each rising edge of the clk16x level. A one-deep holding register
// lets the producer queue the next word while the current frame is shifting,
// so consecutive frames go out with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even parity bit (XOR of the data bits) follows the data
//   undefined -> no parity state and no parity logic
//
// Ports:
//   clk_input  in   system clock, all logic on its rising edge
//   rst_n      in   synchronous reset, active low
//   clk16x     in   16x baud square wave from the divider
//   tx_data    in   word to send (DATA_BITS wide)
//   tx_valid   in   producer offers tx_data
//   tx_ready   out  holding register empty; a word moves on tx_valid & tx_ready
//   txd        out  serial line
//   tx_busy    out  a frame is on the line
//   tx_done    out  one-cycle pulse on the last tick of the final stop bit
//
// State table:
//   state     | meaning
//   S_IDLE    | line high, waiting for a tick with the holding register full
//   S_START   | start bit (low) for OVERSAMPLE ticks
//   S_DATA    | data bit bit_idx for OVERSAMPLE ticks, LSB first
//   S_PARITY  | even parity bit for OVERSAMPLE ticks (parity build only)
//   S_STOP    | stop bit(s) (high), STOP_BITS * OVERSAMPLE ticks

module uart_tx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_input,
  input  logic                 rst_n,
  input  logic                 clk16x,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t               state;
  logic                 c16_d;
  logic                 tick;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 bit_last;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign tick     = clk16x & ~c16_d;
  assign bit_last = (bit_cnt == CNT_LAST);
  assign tx_ready = ~hold_full;

  always_ff @(posedge clk_input) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      c16_d     <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      txd       <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      c16_d   <= clk16x;
      tx_done <= 1'b0;

      // Loads only into an empty register; the FSM only takes from a full
      // one, so a load and a take can never collide in the same cycle.
      if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end

      if (tick) begin
        if (state != S_IDLE) begin
          bit_cnt <= bit_last ? '0 : bit_cnt + CNT_W'(1);
        end

        case (state)
          S_IDLE: begin
            if (hold_full) begin
              shift     <= hold_data;
              hold_full <= 1'b0;
              bit_cnt   <= '0;
              stop_idx  <= 1'b0;
              txd       <= 1'b0;
              tx_busy   <= 1'b1;
              state     <= S_START;
`ifdef UART_TX_PARITY_EN
              parity    <= ^hold_data;
`endif
            end
          end

          S_START: begin
            if (bit_last) begin
              bit_idx <= '0;
              txd     <= shift[0];
              state   <= S_DATA;
            end
          end

          S_DATA: begin
            if (bit_last) begin
              if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                txd   <= parity;
                state <= S_PARITY;
`else
                txd   <= 1'b1;
                state <= S_STOP;
`endif
              end else begin
                // Next bit is driven straight from shift[1] so txd changes on
                // the same edge the shifter advances.
                shift   <= shift >> 1;
                txd     <= shift[1];
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
          end

`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (bit_last) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end
          end
`endif

          S_STOP: begin
            if (bit_last) begin
              if (stop_idx == STOP_LAST) begin
                tx_done  <= 1'b1;
                stop_idx <= 1'b0;
                if (hold_full) begin
                  // Back-to-back: the next start bit begins on this tick.
                  shift     <= hold_data;
                  hold_full <= 1'b0;
                  txd       <= 1'b0;
                  state     <= S_START;
`ifdef UART_TX_PARITY_EN
                  parity    <= ^hold_data;
`endif
                end else begin
                  tx_busy <= 1'b0;
                  state   <= S_IDLE;
                end
              end else begin
                stop_idx <= 1'b1;
              end
            end
          end

          default: begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_16x.sv
module tb_uart_tx_16x;

  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int OS   = 16;
  localparam int DIV  = 4;          // clk16x period in clk_input cycles
  localparam int BITC = OS * DIV;   // clk_input cycles per bit
`ifdef UART_TX_PARITY_EN
  localparam int NB = 1 + DB + 1 + SB;
`else
  localparam int NB = 1 + DB + SB;
`endif

  logic          clk_input = 1'b0;
  logic          rst_n     = 1'b0;
  logic          clk16x    = 1'b0;
  logic [DB-1:0] tx_data   = '0;
  logic          tx_valid  = 1'b0;
  logic          tx_ready;
  logic          txd;
  logic          tx_busy;
  logic          tx_done;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  logic busy_drop = 1'b0;
  logic freeze    = 1'b0;
  logic [1:0] c16_cnt = 2'd0;

  uart_tx_16x #(.DATA_BITS(DB), .STOP_BITS(SB), .OVERSAMPLE(OS)) dut (
    .clk_input(clk_input),
    .rst_n    (rst_n),
    .clk16x   (clk16x),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk_input = ~clk_input;

  always @(posedge clk_input) cyc <= cyc + 1;

  // clk16x: period DIV cycles, changes 1 time unit after the clock edge.
  initial begin
    forever begin
      @(posedge clk_input);
      #1;
      if (!freeze) begin
        c16_cnt = c16_cnt + 2'd1;
        clk16x  = c16_cnt[1];
      end
    end
  end

  always @(negedge clk_input) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (!tx_busy) busy_drop <= 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line levels for one frame, index 0 = start bit.
  function automatic logic [NB-1:0] frame_bits(input logic [DB-1:0] d);
    logic [NB-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+DB] = ^d;
`endif
    return f;
  endfunction

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_input);
  endtask

  task automatic wait_start(output int t0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_input);
      if (txd === 1'b0) break;
    end
    chk("start_seen", {31'b0, txd}, 32'd0);
    t0 = cyc;
  endtask

  task automatic send(input logic [DB-1:0] d, output int acc);
    @(negedge clk_input);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) break;
      @(negedge clk_input);
    end
    chk("send_ready", {31'b0, tx_ready}, 32'd1);
    @(negedge clk_input);
    tx_valid = 1'b0;
    acc = cyc;
  endtask

  // Holds tx_valid with data changing every cycle until tx_ready rises;
  // returns the value that was present at the accepting edge.
  task automatic hold_send(output logic [DB-1:0] v, output int acc);
    int waited;
    waited = 0;
    @(negedge clk_input);
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tx_data = DB'(cyc * 7 + 3);
      if (tx_ready) break;
      waited++;
      @(negedge clk_input);
    end
    chk("hold_waited", {31'b0, (waited > 100)}, 32'd1);
    v = tx_data;
    @(negedge clk_input);
    tx_valid = 1'b0;
    acc = cyc;
  endtask

  // Checks first and last cycle of every bit; bits after sbit are delayed
  // by slen cycles, bit sbit itself is stretched by slen.
  task automatic check_frame(input int t0, input logic [DB-1:0] d,
                             input int sbit, input int slen, input string tag);
    logic [NB-1:0] pat;
    int ts;
    int te;
    pat = frame_bits(d);
    for (int k = 0; k < NB; k++) begin
      ts = t0 + k * BITC + ((k > sbit) ? slen : 0);
      te = t0 + k * BITC + BITC - 1 + ((k >= sbit) ? slen : 0);
      wait_to(ts);
      chk($sformatf("%s_b%0d_first", tag, k), {31'b0, txd}, {31'b0, pat[k]});
      wait_to(te);
      chk($sformatf("%s_b%0d_last", tag, k), {31'b0, txd}, {31'b0, pat[k]});
    end
    chk($sformatf("%s_done_early", tag), {31'b0, tx_done}, 32'd0);
    wait_to(t0 + NB * BITC + slen);
    chk($sformatf("%s_done", tag), {31'b0, tx_done}, 32'd1);
  endtask

  int t0, acc1, acc2, acc3, dd, fs;
  logic [DB-1:0] hv;
  logic b2b_drop;

  initial begin
    // Reset state
    repeat (3) @(negedge clk_input);
    chk("rst_txd",   {31'b0, txd},      32'd1);
    chk("rst_ready", {31'b0, tx_ready}, 32'd1);
    chk("rst_busy",  {31'b0, tx_busy},  32'd0);
    chk("rst_done",  {31'b0, tx_done},  32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_input);

    // Single byte 0xA5
    dd = done_cnt;
    send(8'hA5, acc1);
    wait_start(t0);
    chk("a5_busy", {31'b0, tx_busy}, 32'd1);
    check_frame(t0, 8'hA5, 99, 0, "a5");
    repeat (3) @(negedge clk_input);
    chk("a5_done_once", done_cnt, dd + 1);
    chk("a5_idle_busy", {31'b0, tx_busy}, 32'd0);
    chk("a5_idle_txd",  {31'b0, txd},     32'd1);

    // Back-to-back 0x00, 0xFF, then a held-valid word queued behind them
    repeat (10) @(negedge clk_input);
    dd = done_cnt;
    fork
      begin
        send(8'h00, acc1);
        send(8'hFF, acc2);
        hold_send(hv, acc3);
      end
      begin
        wait_start(t0);
        busy_drop = 1'b0;
        check_frame(t0, 8'h00, 99, 0, "b2b0");
        check_frame(t0 + NB * BITC, 8'hFF, 99, 0, "b2b1");
        b2b_drop = busy_drop;
        check_frame(t0 + 2 * NB * BITC, hv, 99, 0, "hold");
      end
    join
    chk("b2b_accept", acc2, t0 + 1);
    chk("hold_accept", acc3, t0 + NB * BITC + 1);
    chk("b2b_busy_kept", {31'b0, b2b_drop}, 32'd0);
    repeat (3) @(negedge clk_input);
    chk("b2b_done_cnt", done_cnt, dd + 3);
    chk("b2b_idle_busy", {31'b0, tx_busy}, 32'd0);

`ifdef UART_TX_PARITY_EN
    repeat (10) @(negedge clk_input);
    send(8'h07, acc1);
    wait_start(t0);
    check_frame(t0, 8'h07, 99, 0, "par07");
    repeat (10) @(negedge clk_input);
    send(8'h03, acc1);
    wait_start(t0);
    check_frame(t0, 8'h03, 99, 0, "par03");
`endif

    // Stall: clk16x frozen high for 100 cycles during data bit 2
    repeat (10) @(negedge clk_input);
    send(8'hA5, acc1);
    wait_start(t0);
    fork
      check_frame(t0, 8'hA5, 3, 100, "stall");
      begin
        wait_to(t0 + 3 * BITC + 10);
        for (int i = 0; i < 8; i++) begin
          if (clk16x) break;
          @(negedge clk_input);
        end
        freeze = 1'b1;
        fs = cyc;
        wait_to(fs + 50);
        chk("stall_txd_mid", {31'b0, txd}, 32'd1);
        wait_to(fs + 100);
        freeze = 1'b0;
      end
    join

    // Reset mid-frame while sending 0x55 (data bit 1 = 0 on the line)
    repeat (10) @(negedge clk_input);
    send(8'h55, acc1);
    wait_start(t0);
    wait_to(t0 + 2 * BITC + 10);
    chk("rst_mid_pre_txd", {31'b0, txd}, 32'd0);
    dd = done_cnt;
    rst_n = 1'b0;
    @(negedge clk_input);
    chk("rst_mid_txd",   {31'b0, txd},      32'd1);
    chk("rst_mid_busy",  {31'b0, tx_busy},  32'd0);
    chk("rst_mid_ready", {31'b0, tx_ready}, 32'd1);
    @(negedge clk_input);
    rst_n = 1'b1;
    repeat (800) @(negedge clk_input);
    chk("rst_mid_no_done", done_cnt, dd);
    chk("rst_mid_idle_txd",  {31'b0, txd},     32'd1);
    chk("rst_mid_idle_busy", {31'b0, tx_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
